// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider: FSM states, result-valid levels,
// and a conditional two's complement negate used for operand magnitudes and sign fixup.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } div_state_e;

  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;

  // Widest operand neg_if can serve; callers zero-extend in and truncate out.
  localparam int DIV_MAX_W = 128;

  function automatic logic [DIV_MAX_W-1:0] neg_if(input logic                 cond,
                                                  input logic [DIV_MAX_W-1:0] x);
    return cond ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_iter_param_if.sv
// Operand/result handshake bundle for div_iter_param; the divider takes the slave side,
// the issuing pipeline stage (or bench) takes the master side.
interface div_iter_param_if #(
  parameter int WIDTH = 32
) ();

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic                 signed_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 busy_o;

  modport slave (
    input  in_valid_i, signed_i, opdata1_i, opdata2_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, busy_o
  );

  modport master (
    output in_valid_i, signed_i, opdata1_i, opdata2_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, busy_o
  );

endinterface

// File: rtl/div_clz.sv
// Combinational leading-zero count; zero latency, no handshake.
// An all-zero input reports WIDTH.
module div_clz #(
  parameter int WIDTH = 32,
  parameter int LZW   = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [LZW-1:0]   lz_o
);

  logic found;

  always_comb begin
    lz_o  = LZW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && val_i[i]) begin
        lz_o  = LZW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_iter_param.sv
// Iterative restoring divider, one quotient bit per cycle; WIDTH+2 cycles (fewer with SKIP_LZ, 1 for /0).
// Accepts only in IDLE; the result is held in DONE until out_ready_i, flush aborts from any state.
module div_iter_param
  import div_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit SKIP_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  div_iter_param_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  typedef logic [WIDTH-1:0] word_t;

  div_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  word_t              rem_q;
  word_t              q_sr_q;
  word_t              divisor_q;
  logic               sign1_q;
  logic               sign2_q;
  logic               sgn_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] result_q;

  word_t              abs_a;
  word_t              abs_b;
  logic [CW-1:0]      lz;
  logic [WIDTH:0]     trial;
  word_t              rem_d;
  word_t              q_sr_d;
  word_t              q_fix;
  word_t              r_fix;

  always_comb begin
    abs_a = WIDTH'(neg_if(bus.signed_i & bus.opdata1_i[WIDTH-1], DIV_MAX_W'(bus.opdata1_i)));
    abs_b = WIDTH'(neg_if(bus.signed_i & bus.opdata2_i[WIDTH-1], DIV_MAX_W'(bus.opdata2_i)));

    // The partial remainder is always below the divisor, so a failed trial fits WIDTH bits.
    trial = {rem_q, q_sr_q[WIDTH-1]} - {1'b0, divisor_q};
    if (!trial[WIDTH]) begin
      rem_d  = trial[WIDTH-1:0];
      q_sr_d = {q_sr_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d  = {rem_q[WIDTH-2:0], q_sr_q[WIDTH-1]};
      q_sr_d = {q_sr_q[WIDTH-2:0], 1'b0};
    end

    q_fix = WIDTH'(neg_if(sgn_q & (sign1_q ^ sign2_q), DIV_MAX_W'(q_sr_q)));
    r_fix = WIDTH'(neg_if(sgn_q & sign1_q, DIV_MAX_W'(rem_q)));
  end

  if (SKIP_LZ) begin : g_lz
    div_clz #(
      .WIDTH (WIDTH),
      .LZW   (CW)
    ) u_clz (
      .val_i (abs_a),
      .lz_o  (lz)
    );
  end else begin : g_nolz
    assign lz = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      q_sr_q      <= '0;
      divisor_q   <= '0;
      sign1_q     <= 1'b0;
      sign2_q     <= 1'b0;
      sgn_q       <= 1'b0;
      out_valid_q <= DIV_RESULT_NOT_READY;
      result_q    <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= DIV_RESULT_NOT_READY;
      result_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            if (bus.opdata2_i == '0) begin
              result_q    <= {bus.opdata1_i, {WIDTH{1'b1}}};
              out_valid_q <= DIV_RESULT_READY;
              state_q     <= DONE;
            end else begin
              sign1_q   <= bus.opdata1_i[WIDTH-1];
              sign2_q   <= bus.opdata2_i[WIDTH-1];
              sgn_q     <= bus.signed_i;
              divisor_q <= abs_b;
              rem_q     <= '0;
              q_sr_q    <= abs_a << lz;
              cnt_q     <= lz;
              // A zero dividend leaves nothing to iterate over.
              state_q   <= (lz == CW'(WIDTH)) ? FIXUP : CALC;
            end
          end
        end
        CALC: begin
          rem_q  <= rem_d;
          q_sr_q <= q_sr_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIXUP;
          end
        end
        FIXUP: begin
          result_q    <= {r_fix, q_fix};
          out_valid_q <= DIV_RESULT_READY;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready_i) begin
            out_valid_q <= DIV_RESULT_NOT_READY;
            result_q    <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;

endmodule

// File: tb/tb_div_iter_param.sv
// Directed bench for div_iter_param: one instance without and one with leading-zero skip,
// checking results, accept-to-valid latency, hold, flush and asynchronous reset.
module tb_div_iter_param;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  div_iter_param_if #(.WIDTH(32)) if0 ();
  div_iter_param_if #(.WIDTH(32)) if1 ();

  div_iter_param #(.WIDTH(32), .SKIP_LZ(1'b0)) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (if0)
  );

  div_iter_param #(.WIDTH(32), .SKIP_LZ(1'b1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (if1)
  );

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic out_vld(input bit skip);
    return skip ? if1.out_valid_o : if0.out_valid_o;
  endfunction

  task automatic drive_op(input bit skip, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic vld);
    if (skip) begin
      if1.signed_i = sgn; if1.opdata1_i = a; if1.opdata2_i = b; if1.in_valid_i = vld;
    end else begin
      if0.signed_i = sgn; if0.opdata1_i = a; if0.opdata2_i = b; if0.in_valid_i = vld;
    end
  endtask

  // Latency counts the accept edge as cycle 1 up to the edge that raises out_valid_o.
  task automatic run_op(input bit skip, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat);
    @(negedge clk);
    drive_op(skip, sgn, a, b, 1'b1);
    @(posedge clk); #1;
    drive_op(skip, sgn, a, b, 1'b0);
    lat = 1;
    while (!out_vld(skip) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = skip ? if1.result_o : if0.result_o;
  endtask

  task automatic pop(input bit skip, input string tag);
    @(negedge clk);
    if (skip) if1.out_ready_i = 1'b1; else if0.out_ready_i = 1'b1;
    @(posedge clk); #1;
    if (skip) if1.out_ready_i = 1'b0; else if0.out_ready_i = 1'b0;
    chk_val({tag, "_vld_clr"}, 64'(out_vld(skip)), 64'd0);
    chk_val({tag, "_res_clr"}, skip ? if1.result_o : if0.result_o, 64'd0);
    chk_val({tag, "_rdy"}, 64'(skip ? if1.in_ready_o : if0.in_ready_o), 64'd1);
  endtask

  task automatic do_div(input bit skip, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [31:0] exp_r, input int exp_lat,
                        input string tag);
    logic [63:0] res;
    int          lat;
    run_op(skip, sgn, a, b, res, lat);
    chk_val({tag, "_res"}, res, {exp_r, exp_q});
    chk_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    pop(skip, tag);
  endtask

  task automatic chk_idle0(input string tag);
    chk_val({tag, "_rdy"},  64'(if0.in_ready_o),  64'd1);
    chk_val({tag, "_vld"},  64'(if0.out_valid_o), 64'd0);
    chk_val({tag, "_busy"}, 64'(if0.busy_o),      64'd0);
    chk_val({tag, "_res"},  if0.result_o,         64'd0);
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] held;
    int          lat;
    logic        seen;

    drive_op(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive_op(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    if0.out_ready_i = 1'b0;
    if1.out_ready_i = 1'b0;

    #12;
    chk_idle0("reset0");
    chk_val("reset1_rdy", 64'(if1.in_ready_o), 64'd1);
    chk_val("reset1_vld", 64'(if1.out_valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_div(0, 0, 32'd100,        32'd7,          32'd14,         32'd2,          34, "u_100_7");
    do_div(0, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  34, "s_m7_2");
    do_div(0, 1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          34, "s_7_m2");
    do_div(0, 1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  34, "s_m7_m2");
    do_div(0, 0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,        1, "dz");
    do_div(0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          34, "ovf");
    do_div(0, 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  34, "u_big");
    do_div(1, 0, 32'd5,          32'd3,          32'd1,          32'd2,           5, "lz_5_3");
    do_div(1, 0, 32'd0,          32'd9,          32'd0,          32'd0,           2, "lz_0_9");
    do_div(1, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,   5, "lz_s_m7_2");
    do_div(1, 0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          34, "lz_full");
    do_div(1, 1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,   1, "lz_dz_neg");

    // Result must sit unchanged while the consumer stalls.
    run_op(0, 0, 32'd100, 32'd7, res, lat);
    held = res;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk_val("hold_res", if0.result_o, held);
      chk_val("hold_rdy", 64'(if0.in_ready_o), 64'd0);
    end
    chk_val("hold_vld", 64'(if0.out_valid_o), 64'd1);
    pop(0, "hold");

    // Flush during the fifth CALC cycle.
    @(negedge clk);
    drive_op(0, 0, 32'd100, 32'd7, 1'b1);
    @(posedge clk); #1;
    drive_op(0, 0, 32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_val("flush_pre_busy", 64'(if0.busy_o), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_idle0("flush_calc");
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | if0.out_valid_o;
    end
    chk_val("flush_no_vld", 64'(seen), 64'd0);

    // Flush coinciding with an accept drops the operands.
    @(negedge clk);
    drive_op(0, 0, 32'd9, 32'd3, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    drive_op(0, 0, 32'd9, 32'd3, 1'b0);
    flush = 1'b0;
    chk_idle0("flush_acc");
    repeat (5) @(posedge clk);
    #1;
    chk_val("flush_acc_late_vld", 64'(if0.out_valid_o), 64'd0);

    do_div(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 34, "post_flush");

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    drive_op(0, 0, 32'd100, 32'd7, 1'b1);
    @(posedge clk); #1;
    drive_op(0, 0, 32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_idle0("rst_mid");
    @(negedge clk);
    rst = 1'b1;

    do_div(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 34, "post_rst");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
